// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the compression line packer.
package cmp_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_e;

    function automatic int beats_f(input int cache_line, input int lanes, input int word);
        return cache_line / (lanes * word);
    endfunction

    function automatic int fill_w_f(input int cache_line, input int lanes, input int max_code_len);
        return $clog2(cache_line + lanes * max_code_len) + 32'd1;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/cmp_beat_merge.sv
// Combinational merge of one beat: clamps and masks each lane, then packs the
// lanes LSB-first at their prefix-sum offsets and reports the beat bit count.
module cmp_beat_merge
    import cmp_pkg::*;
#(
    parameter  int LANES        = 32'd2,
    parameter  int MAX_CODE_LEN = 32'd34,
    parameter  int LEN_W        = 32'd6,
    localparam int BV_W         = LANES * MAX_CODE_LEN,
    localparam int OFF_W        = $clog2(BV_W + 32'd1)
) (
    input  logic [BV_W-1:0]        code,
    input  logic [LANES*LEN_W-1:0] code_len,
    output logic [BV_W-1:0]        beat_vec,
    output logic [OFF_W-1:0]       beat_len
);

    logic [OFF_W-1:0]        off_s;
    logic [OFF_W-1:0]        len_s;
    logic [MAX_CODE_LEN-1:0] lane_s;

    // Walk the lanes in order, accumulating the running offset of each lane.
    always_comb begin
        beat_vec = '0;
        off_s    = '0;
        len_s    = '0;
        lane_s   = '0;
        for (int k = 0; k < LANES; k++) begin
            len_s = OFF_W'(clamp_len(32'(code_len[k*LEN_W +: LEN_W]), MAX_CODE_LEN));
            for (int b = 0; b < MAX_CODE_LEN; b++) begin
                lane_s[b] = (b < int'(len_s)) ? code[k*MAX_CODE_LEN + b] : 1'b0;
            end
            beat_vec = beat_vec | (BV_W'(lane_s) << off_s);
            off_s    = off_s + len_s;
        end
        beat_len = off_s;
    end

endmodule

// File: rtl/cmp_line_packer.sv
// Packs BEATS input beats into one cache line, falling back to the raw words
// when the packed size exceeds the line. Optional macro: CMP_PACKER_STATS_EN.
module cmp_line_packer
    import cmp_pkg::*;
#(
    parameter int LANES        = 32'd2,
    parameter int WORD         = 32'd32,
    parameter int CACHE_LINE   = 32'd128,
    parameter int MAX_CODE_LEN = 32'd34,
    parameter int LEN_W        = 32'd6
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [LANES*MAX_CODE_LEN-1:0] i_code,
    input  logic [LANES*LEN_W-1:0]        i_code_len,
    input  logic [LANES*WORD-1:0]         i_raw,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [CACHE_LINE-1:0]         o_line,
    output logic [$clog2(CACHE_LINE):0]   o_len,
    output logic                          o_compressed
`ifdef CMP_PACKER_STATS_EN
    ,
    output logic [31:0]                   o_cnt_cmp,
    output logic [31:0]                   o_cnt_raw
`endif
);

    localparam int BEATS     = beats_f(CACHE_LINE, LANES, WORD);
    localparam int FILL_W    = fill_w_f(CACHE_LINE, LANES, MAX_CODE_LEN);
    localparam int BV_W      = LANES * MAX_CODE_LEN;
    localparam int OFF_W     = $clog2(BV_W + 32'd1);
    localparam int CNT_W     = (BEATS > 32'd1) ? $clog2(BEATS) : 32'd1;
    localparam int LEN_OUT_W = $clog2(CACHE_LINE) + 32'd1;
    localparam int RAW_W     = LANES * WORD;

    state_e                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        beat_cnt_r;
    logic [FILL_W-1:0]       fill_r, total_s;
    logic                    ovf_r, ovf_next_s;
    logic [CACHE_LINE-1:0]   acc_r, acc_next_s, raw_r, raw_next_s;
    logic [CACHE_LINE-1:0]   line_r;
    logic [LEN_OUT_W-1:0]    len_r;
    logic                    cmp_r;
    logic                    accept_s, pop_s, last_beat_s;
    logic [BV_W-1:0]         beat_vec_s;
    logic [OFF_W-1:0]        beat_len_s;

    cmp_beat_merge #(
        .LANES        (LANES),
        .MAX_CODE_LEN (MAX_CODE_LEN),
        .LEN_W        (LEN_W)
    ) u_merge (
        .code     (i_code),
        .code_len (i_code_len),
        .beat_vec (beat_vec_s),
        .beat_len (beat_len_s)
    );

    // Next-line candidates: overflow decision, shifted accumulator and raw copy.
    always_comb begin
        total_s     = fill_r + FILL_W'(beat_len_s);
        ovf_next_s  = ovf_r | (total_s > FILL_W'(CACHE_LINE));
        acc_next_s  = acc_r | (CACHE_LINE'(beat_vec_s) << fill_r);
        raw_next_s  = raw_r;
        raw_next_s[beat_cnt_r*RAW_W +: RAW_W] = i_raw;
        last_beat_s = (beat_cnt_r == CNT_W'(BEATS - 32'd1));
    end

    // Line framing FSM: next state and handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        accept_s    = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ACCUM: begin
                o_ready  = 1'b1;
                accept_s = i_valid;
                if (i_valid && last_beat_s) begin
                    state_nxt_s = EMIT;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            EMIT: begin
                o_valid = 1'b1;
                pop_s   = i_ready;
                if (i_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = EMIT;
                end
            end
            default: state_nxt_s = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Accumulator, fill, sticky overflow, raw backup and beat counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            acc_r      <= '0;
            raw_r      <= '0;
            fill_r     <= '0;
            ovf_r      <= 1'b0;
            beat_cnt_r <= '0;
        end else if (pop_s) begin
            acc_r      <= '0;
            raw_r      <= '0;
            fill_r     <= '0;
            ovf_r      <= 1'b0;
            beat_cnt_r <= '0;
        end else if (accept_s) begin
            raw_r      <= raw_next_s;
            ovf_r      <= ovf_next_s;
            beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + CNT_W'(1);
            // Once the line has overflowed the packed image is useless; freeze it.
            if (!ovf_next_s) begin
                acc_r  <= acc_next_s;
                fill_r <= total_s;
            end else begin
                acc_r  <= acc_r;
                fill_r <= fill_r;
            end
        end else begin
            acc_r      <= acc_r;
            raw_r      <= raw_r;
            fill_r     <= fill_r;
            ovf_r      <= ovf_r;
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Output line register, loaded on the last beat and held through EMIT.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            line_r <= '0;
            len_r  <= '0;
            cmp_r  <= 1'b0;
        end else if (accept_s && last_beat_s) begin
            if (ovf_next_s) begin
                line_r <= raw_next_s;
                len_r  <= LEN_OUT_W'(CACHE_LINE);
                cmp_r  <= 1'b0;
            end else begin
                line_r <= acc_next_s;
                len_r  <= LEN_OUT_W'(total_s);
                cmp_r  <= 1'b1;
            end
        end else begin
            line_r <= line_r;
            len_r  <= len_r;
            cmp_r  <= cmp_r;
        end
    end

    assign o_line       = line_r;
    assign o_len        = len_r;
    assign o_compressed = cmp_r;

`ifdef CMP_PACKER_STATS_EN
    logic [31:0] cnt_cmp_r, cnt_raw_r;

    // Saturating counts of emitted compressed and raw lines.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_cmp_r <= 32'd0;
            cnt_raw_r <= 32'd0;
        end else if (pop_s) begin
            if (cmp_r) begin
                cnt_cmp_r <= (cnt_cmp_r == 32'hFFFF_FFFF) ? cnt_cmp_r : cnt_cmp_r + 32'd1;
                cnt_raw_r <= cnt_raw_r;
            end else begin
                cnt_cmp_r <= cnt_cmp_r;
                cnt_raw_r <= (cnt_raw_r == 32'hFFFF_FFFF) ? cnt_raw_r : cnt_raw_r + 32'd1;
            end
        end else begin
            cnt_cmp_r <= cnt_cmp_r;
            cnt_raw_r <= cnt_raw_r;
        end
    end

    assign o_cnt_cmp = cnt_cmp_r;
    assign o_cnt_raw = cnt_raw_r;
`endif

endmodule
